inst_fetch_queue: RTL and testbench
===================================

# inst_fetch_queue

Instruction fetch front-end placed between the PC/instruction-memory side and the IF_ID pipeline register. It owns the fetch PC, issues in-order word requests to instruction memory over a valid/ready request channel with fixed-order responses, and buffers returned instructions with their PCs in a small FIFO. IF_ID drains the FIFO head. A taken branch from branchUnit redirects fetch, empties the queue, and discards responses still in flight.

## Interface
Parameters:
- DEPTH, 4: FIFO entries; also the cap on total in-flight plus buffered instructions (power of two, ≥2).
- RESET_PC, 32'h0000_0000: fetch PC after reset (`DataBusReset`).

Ports:
- clk  in  1  pipeline clock, rising edge.
- resetIn  in  1  asynchronous, active-low reset.
- flush  in  1  branch taken (branchFlag); redirect this cycle.
- redirectAddr  in  32  branch target (pcToPc); valid when flush=1.
- stall  in  1  IF_ID locker (IFIDlock); head is not consumed while 1.
- memReqValid  out  1  request to instruction memory.
- memReqReady  in  1  memory accepts the request this cycle.
- memReqAddr  out  32  word address of the request (fetchPc).
- memRspValid  in  1  response returned this cycle, strictly in request order.
- memRspData  in  32  instruction word.
- outValid  out  1  FIFO head valid toward IF_ID.
- outInst  out  32  head instruction; `NopInst` (32'h0000_0013) when outValid=0.
- outPc  out  32  head PC; 0 when outValid=0.

## Operation
- State: fetchPc (next request address), rspPc (PC of next kept response), FIFO count, outstanding (accepted, not yet returned, kept), dropPending (in flight, to discard).
- Issue: memReqValid = !flush && (count + outstanding + dropPending < DEPTH). Accept = memReqValid && memReqReady → fetchPc += 4, outstanding += 1.
- Response with dropPending>0: dropPending −= 1, data discarded, rspPc unchanged.
- Response with dropPending=0: push {rspPc, memRspData}, rspPc += 4, outstanding −= 1.
- Pop: outValid && !stall → head removed. Push and pop in the same cycle both occur; count unchanged.
- flush=1 (priority over everything): FIFO emptied; fetchPc ← redirectAddr; rspPc ← redirectAddr; dropPending ← dropPending + outstanding + (memRspValid ? −1 : 0) applied consistently, with a response arriving in the flush cycle always discarded; outstanding ← 0; no request accepted (memReqValid=0); no pop.
- Bits [1:0] of redirectAddr are passed through unchanged; alignment is branchUnit's responsibility.
- memRspValid with outstanding=0 and dropPending=0 is a protocol error; the response is ignored.

## Timing
- Reset (async assert, sync release): fetchPc=rspPc=RESET_PC, count=outstanding=dropPending=0, memReqValid=1 on the first cycle after release, outValid=0, outInst=`NopInst`, outPc=0.
- Response accepted at edge N → outValid=1 after edge N (visible in cycle N+1); no combinational rsp→out bypass.
- outValid/outInst/outPc are driven from registers only; memReqValid is combinational from counters and flush.
- Flush at edge N → outValid=0 in cycle N+1; first request to redirectAddr is issued in cycle N+1 if credit allows.
- Reset mid-operation clears all state immediately; in-flight memory responses after release must not occur (memory is reset on the same reset).
- Full: count + outstanding + dropPending = DEPTH → memReqValid=0 until a pop or drop frees a slot.

## Structure
- `define.v` additions: `DataSize`, `DataBusReset`, `NopInst`, `FetchQueueDepth`.
- One sub-module, `fetch_fifo`: synchronous DEPTH-entry FIFO of 64-bit {pc, inst} entries with push, pop, clear, count, and head outputs; wrap-around pointers of log2(DEPTH) bits plus a count of log2(DEPTH)+1 bits.
- Top level holds the PC registers, credit and drop counters, and output muxing.

## Test plan
- Reset release, memReqReady=1, 1-cycle memory, stall=0 → requests 0x0, 0x4, 0x8…; outPc 0x0, 0x4 on consecutive cycles, with outInst matching memory.
- stall=1 held for 10 cycles → exactly DEPTH=4 entries buffered (0x0–0xC), memReqValid=0; release → 0x0..0xC drain in order, no loss or duplication.
- Two requests in flight, flush with redirectAddr=0x40 → both late responses dropped; next outPc=0x40 with the instruction at 0x40.
- Flush in the same cycle as memRspValid and as a pop → response discarded, outValid=0 next cycle, FIFO count=0.
- memReqReady toggled randomly with 0–3 cycle response latency over 1000 cycles → outPc strictly +4 between flushes; count + outstanding + dropPending never exceeds 4.
- resetIn pulsed low mid-stream with queue full → all outputs at reset values asynchronously; fetch restarts at 0x0.

Source files
------------

// File: rtl/inst_fetch_queue_pkg.sv
// Shared constants and types for the instruction fetch front-end.
package inst_fetch_queue_pkg;

  localparam int unsigned DataSize        = 32;
  localparam logic [31:0] DataBusReset    = 32'h0000_0000;
  localparam logic [31:0] NopInst         = 32'h0000_0013;
  localparam int unsigned FetchQueueDepth = 4;

  typedef struct packed {
    logic [DataSize-1:0] pc;
    logic [DataSize-1:0] inst;
  } fetchEntry_t;

  typedef enum logic [1:0] {
    RspNone,
    RspKeep,
    RspDrop
  } rspKind_e;

endpackage

// File: rtl/inst_fetch_queue_fifo.sv
// Synchronous FIFO of {pc, inst} entries with a single-cycle clear.
module fetch_fifo
  import inst_fetch_queue_pkg::*;
#(
  parameter int unsigned DEPTH = FetchQueueDepth
) (
  input  logic                     clk,
  input  logic                     resetIn,
  input  logic                     push,
  input  fetchEntry_t              pushData,
  input  logic                     pop,
  input  logic                     clear,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     headValid,
  output fetchEntry_t              headData
);

  localparam int unsigned PtrW = $clog2(DEPTH);

  fetchEntry_t          mem [DEPTH];
  logic [PtrW-1:0]      wrPtr;
  logic [PtrW-1:0]      rdPtr;

  // DEPTH is a power of two, so the pointers wrap by natural overflow.
  always_ff @(posedge clk or negedge resetIn) begin
    if (!resetIn) begin
      wrPtr <= '0;
      rdPtr <= '0;
      count <= '0;
    end else if (clear) begin
      wrPtr <= '0;
      rdPtr <= '0;
      count <= '0;
    end else begin
      if (push) wrPtr <= wrPtr + 1'b1;
      if (pop)  rdPtr <= rdPtr + 1'b1;
      if (push && !pop)      count <= count + 1'b1;
      else if (pop && !push) count <= count - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push && !clear) mem[wrPtr] <= pushData;
  end

  assign headValid = (count != '0);
  assign headData  = mem[rdPtr];

endmodule

// File: rtl/inst_fetch_queue.sv
// Fetch front-end: owns the fetch PC, issues credit-limited memory requests,
// buffers returned instructions and discards responses orphaned by a redirect.
module inst_fetch_queue
  import inst_fetch_queue_pkg::*;
#(
  parameter int unsigned DEPTH    = FetchQueueDepth,
  parameter logic [31:0] RESET_PC = DataBusReset
) (
  input  logic                clk,
  input  logic                resetIn,
  input  logic                flush,
  input  logic [DataSize-1:0] redirectAddr,
  input  logic                stall,
  output logic                memReqValid,
  input  logic                memReqReady,
  output logic [DataSize-1:0] memReqAddr,
  input  logic                memRspValid,
  input  logic [DataSize-1:0] memRspData,
  output logic                outValid,
  output logic [DataSize-1:0] outInst,
  output logic [DataSize-1:0] outPc
);

  localparam int unsigned CntW = $clog2(DEPTH) + 1;

  logic [DataSize-1:0] fetchPc;
  logic [DataSize-1:0] rspPc;
  logic [CntW-1:0]     count;
  logic [CntW-1:0]     outstanding;
  logic [CntW-1:0]     dropPending;
  logic [CntW+1:0]     inUse;
  logic                memReqAccept;
  logic                fifoPush;
  logic                fifoPop;
  logic                headValid;
  fetchEntry_t         headData;
  rspKind_e            rspKind;

  assign inUse        = {2'b00, count} + {2'b00, outstanding} + {2'b00, dropPending};
  assign memReqValid  = !flush && (inUse < (CntW+2)'(DEPTH));
  assign memReqAccept = memReqValid && memReqReady;
  assign memReqAddr   = fetchPc;

  // Responses with nothing outstanding or pending drop are ignored.
  always_comb begin
    rspKind = RspNone;
    if (memRspValid) begin
      if (dropPending != '0)      rspKind = RspDrop;
      else if (outstanding != '0) rspKind = RspKeep;
    end
  end

  assign fifoPush = (rspKind == RspKeep) && !flush;
  assign fifoPop  = headValid && !stall && !flush;

  always_ff @(posedge clk or negedge resetIn) begin
    if (!resetIn) begin
      fetchPc     <= RESET_PC;
      rspPc       <= RESET_PC;
      outstanding <= '0;
      dropPending <= '0;
    end else if (flush) begin
      // Everything still in flight becomes a drop; a response landing now is consumed here.
      fetchPc     <= redirectAddr;
      rspPc       <= redirectAddr;
      outstanding <= '0;
      dropPending <= dropPending + outstanding - CntW'(rspKind != RspNone);
    end else begin
      if (memReqAccept) fetchPc <= fetchPc + 32'd4;
      if (rspKind == RspKeep) rspPc <= rspPc + 32'd4;
      if (rspKind == RspDrop) dropPending <= dropPending - 1'b1;
      outstanding <= outstanding + CntW'(memReqAccept) - CntW'(rspKind == RspKeep);
    end
  end

  fetch_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk      (clk),
    .resetIn  (resetIn),
    .push     (fifoPush),
    .pushData ('{pc: rspPc, inst: memRspData}),
    .pop      (fifoPop),
    .clear    (flush),
    .count    (count),
    .headValid(headValid),
    .headData (headData)
  );

  assign outValid = headValid;
  assign outInst  = headValid ? headData.inst : NopInst;
  assign outPc    = headValid ? headData.pc   : '0;

endmodule

// File: tb/tb_inst_fetch_queue.sv
// Scoreboard bench for inst_fetch_queue with an in-order memory model.
module tb_inst_fetch_queue;

  logic        clk = 1'b0;
  logic        resetIn;
  logic        flush;
  logic [31:0] redirectAddr;
  logic        stall;
  logic        memReqValid;
  logic        memReqReady;
  logic [31:0] memReqAddr;
  logic        memRspValid;
  logic [31:0] memRspData;
  logic        outValid;
  logic [31:0] outInst;
  logic [31:0] outPc;

  always #5 clk = ~clk;

  inst_fetch_queue #(
    .DEPTH   (4),
    .RESET_PC(32'h0000_0000)
  ) dut (
    .clk         (clk),
    .resetIn     (resetIn),
    .flush       (flush),
    .redirectAddr(redirectAddr),
    .stall       (stall),
    .memReqValid (memReqValid),
    .memReqReady (memReqReady),
    .memReqAddr  (memReqAddr),
    .memRspValid (memRspValid),
    .memRspData  (memRspData),
    .outValid    (outValid),
    .outInst     (outInst),
    .outPc       (outPc)
  );

  typedef struct {
    logic [31:0] addr;
    int          due;
  } req_t;

  int          checks = 0;
  int          errors = 0;
  int          cycle = 0;
  int          extraLat = 0;
  int          lastDue = 0;
  int          acceptCount = 0;
  int          popCount = 0;
  logic [31:0] expQ[$];
  req_t        reqQ[$];

  function automatic logic [31:0] memWord(input logic [31:0] a);
    return a ^ 32'hA5A5_0000;
  endfunction

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Expected delivery order from a fetch start address.
  task automatic startStream(input logic [31:0] base);
    expQ.delete();
    for (int i = 0; i < 256; i++) expQ.push_back(base + 32'(4 * i));
  endtask

  task automatic step(input logic fl, input logic [31:0] ra, input logic st, input logic rdy);
    int d;
    @(negedge clk);
    cycle++;
    flush = fl;
    redirectAddr = ra;
    stall = st;
    memReqReady = rdy;
    if (fl) startStream(ra);
    memRspValid = 1'b0;
    memRspData = '0;
    if (reqQ.size() > 0 && reqQ[0].due <= cycle) begin
      memRspValid = 1'b1;
      memRspData = memWord(reqQ[0].addr);
    end
    #1;
    if (resetIn && memReqValid && memReqReady) begin
      d = cycle + 1 + extraLat;
      if (d < lastDue) d = lastDue;
      lastDue = d;
      reqQ.push_back('{memReqAddr, d});
      acceptCount++;
    end
    if (memRspValid) void'(reqQ.pop_front());
  endtask

  // Monitor: every head consumption is compared against the scoreboard.
  always @(negedge clk) begin : monitor
    logic [31:0] e;
    #3;
    if (resetIn === 1'b1 && outValid && !stall && !flush) begin
      popCount++;
      if (expQ.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL pop: unexpected pc %h, expected no entry", outPc);
      end else begin
        e = expQ.pop_front();
        check32("popPc", outPc, e);
        check32("popInst", outInst, memWord(e));
      end
    end
  end

  initial begin
    int popBefore;
    int sinceFlush;
    logic fl;
    logic [31:0] ra;

    resetIn = 1'b0;
    flush = 1'b0;
    stall = 1'b0;
    memReqReady = 1'b0;
    memRspValid = 1'b0;
    memRspData = '0;
    redirectAddr = '0;
    startStream(32'h0);

    #12;
    check32("rst outValid", 32'(outValid), 32'd0);
    check32("rst outInst", outInst, 32'h0000_0013);
    check32("rst outPc", outPc, 32'h0);
    @(negedge clk);
    resetIn = 1'b1;
    #1;
    check32("post-rst memReqValid", 32'(memReqValid), 32'd1);
    check32("post-rst memReqAddr", memReqAddr, 32'h0);

    // Streaming, 1-cycle memory.
    extraLat = 0;
    repeat (12) step(1'b0, 32'h0, 1'b0, 1'b1);
    #3;
    check32("A pops", 32'(popCount), 32'd10);

    // Stall until full.
    repeat (10) step(1'b0, 32'h0, 1'b1, 1'b1);
    check32("B full memReqValid", 32'(memReqValid), 32'd0);
    check32("B head valid", 32'(outValid), 32'd1);
    check32("B head pc", outPc, 32'h28);
    check32("B credit", 32'(acceptCount - popCount), 32'd4);
    repeat (8) step(1'b0, 32'h0, 1'b0, 1'b1);
    #3;
    check32("B drain pops", 32'(popCount), 32'd18);

    // Flush with requests in flight.
    extraLat = 2;
    repeat (6) step(1'b0, 32'h0, 1'b0, 1'b1);
    step(1'b1, 32'h40, 1'b0, 1'b1);
    check32("C flush memReqValid", 32'(memReqValid), 32'd0);
    popBefore = popCount;
    step(1'b0, 32'h0, 1'b0, 1'b1);
    check32("C after outValid", 32'(outValid), 32'd0);
    check32("C after memReqValid", 32'(memReqValid), 32'd1);
    check32("C after memReqAddr", memReqAddr, 32'h40);
    repeat (12) step(1'b0, 32'h0, 1'b0, 1'b1);
    #3;
    check32("C progress", 32'(popCount > popBefore), 32'd1);

    // Flush coinciding with a response and a pop.
    extraLat = 0;
    repeat (6) step(1'b0, 32'h0, 1'b0, 1'b1);
    check32("D pre outValid", 32'(outValid), 32'd1);
    step(1'b1, 32'h80, 1'b0, 1'b1);
    check32("D flush outValid", 32'(outValid), 32'd1);
    step(1'b0, 32'h0, 1'b0, 1'b1);
    check32("D after outValid", 32'(outValid), 32'd0);
    check32("D after memReqAddr", memReqAddr, 32'h80);
    check32("D after memReqValid", 32'(memReqValid), 32'd1);
    step(1'b0, 32'h0, 1'b0, 1'b1);
    check32("D empty outValid", 32'(outValid), 32'd0);
    repeat (5) step(1'b0, 32'h0, 1'b0, 1'b1);

    // Random ready/latency/stall with occasional redirects.
    popBefore = popCount;
    sinceFlush = 0;
    for (int i = 0; i < 1000; i++) begin
      extraLat = $urandom_range(0, 3);
      fl = ($urandom_range(0, 49) == 0) || (sinceFlush >= 200);
      ra = 32'($urandom_range(0, 1023)) << 2;
      sinceFlush = fl ? 0 : sinceFlush + 1;
      step(fl, ra, ($urandom_range(0, 3) == 0), 1'($urandom_range(0, 1)));
      check32("E inflight bound", 32'(reqQ.size() <= 4), 32'd1);
    end
    #3;
    check32("E progress", 32'(popCount > popBefore), 32'd1);

    // Asynchronous reset while full.
    extraLat = 0;
    repeat (8) step(1'b0, 32'h0, 1'b1, 1'b1);
    check32("F full memReqValid", 32'(memReqValid), 32'd0);
    #2;
    resetIn = 1'b0;
    #1;
    check32("F rst outValid", 32'(outValid), 32'd0);
    check32("F rst outInst", outInst, 32'h0000_0013);
    check32("F rst outPc", outPc, 32'h0);
    reqQ.delete();
    lastDue = 0;
    startStream(32'h0);
    step(1'b0, 32'h0, 1'b0, 1'b0);
    #1;
    resetIn = 1'b1;
    #1;
    check32("F restart memReqAddr", memReqAddr, 32'h0);
    check32("F restart memReqValid", 32'(memReqValid), 32'd1);
    popBefore = popCount;
    repeat (10) step(1'b0, 32'h0, 1'b0, 1'b1);
    #3;
    check32("F restart pops", 32'(popCount - popBefore), 32'd8);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
